fault_conf_ctrl: RTL and testbench
==================================

# fault_conf_ctrl

Fault-confinement controller for the CAN core. It consumes the threshold flags of the transmit and receive error counters and sequences the node through error-active, error-passive and bus-off. It also runs bus-off recovery: it counts 128 sequences of 11 consecutive recessive bits, then clears both error counters. It sits between the error counters, the MAC FSM (error-state outputs) and the host register interface (status and recovery request).

## Interface
Parameters:
- RUN_LEN, 11, consecutive recessive bits forming one recovery sequence
- SEQ_CNT, 128, recovery sequences required before counters are cleared

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low
- tec_ge96  input  1  TEC >= 96
- tec_ge128  input  1  TEC >= 128
- tec_ge256  input  1  TEC >= 256
- rec_ge96  input  1  REC >= 96
- rec_ge128  input  1  REC >= 128
- sample  input  1  one-cycle strobe, bus bit sampled this cycle
- rxbit  input  1  sampled bus value, 1 = recessive, valid when sample=1
- recover_req  input  1  host pulse, starts bus-off recovery (manual mode only)
- erroractive  output  1  node error-active
- errorpassive  output  1  node error-passive
- busoff  output  1  node bus-off
- warning  output  1  TEC or REC >= 96 while not bus-off
- cntrst_n  output  1  active-low clear to both error counters, one cycle
- seqcount  output  8  recovery sequences counted so far, zero-extended

## Operation
- States: ACTIVE, PASSIVE, BOFF_HOLD, BOFF_CNT, CLEAR.
- ACTIVE → BOFF_* if tec_ge256; else → PASSIVE if tec_ge128 | rec_ge128.
- PASSIVE → BOFF_* if tec_ge256; else → ACTIVE if !tec_ge128 & !rec_ge128.
- Bus-off entry target is BOFF_CNT in automatic mode and BOFF_HOLD in manual mode; see Configuration. Bus-off takes priority over passive when both are true.
- BOFF_HOLD → BOFF_CNT on recover_req=1. recover_req is ignored in every other state.
- BOFF_CNT run detection:
  - sample & !rxbit clears the run counter.
  - sample & rxbit increments the run counter.
  - When the run counter reaches RUN_LEN, it returns to 0 and the sequence counter increments in the same cycle.
  - When the sequence counter reaches SEQ_CNT → CLEAR.
- CLEAR: cntrst_n=0 for exactly one cycle, then → ACTIVE unconditionally. TEC/REC flags are ignored in CLEAR.
- Run and sequence counters are zeroed on every bus-off entry and in every state other than BOFF_CNT. sample is ignored outside BOFF_CNT.
- Outputs:
  - erroractive = ACTIVE | CLEAR
  - errorpassive = PASSIVE
  - busoff = BOFF_HOLD | BOFF_CNT
  - warning = (tec_ge96 | rec_ge96) & !busoff
  - seqcount = sequence counter (0..SEQ_CNT)
- Counter widths: run counter $clog2(RUN_LEN+1) bits, sequence counter $clog2(SEQ_CNT+1) bits; SEQ_CNT must be ≤ 255. No wrap: the sequence counter never exceeds SEQ_CNT.

## Timing
- Reset values: state ACTIVE, counters 0; erroractive=1, errorpassive=0, busoff=0, warning=0 (flags low), cntrst_n=1, seqcount=0.
- Moore FSM: a flag change on cycle n moves the state at edge n+1; state outputs change in cycle n+1.
- warning is combinational from the flags and the state.
- With the default parameters, the final sample of the 1408th consecutive recessive bit (11 × 128) in BOFF_CNT gives CLEAR in the next cycle and ACTIVE in the cycle after that.
- The error counters clear at the edge leaving CLEAR, so flags are low by the first ACTIVE cycle.
- A dominant sample mid-sequence loses only the current run; completed sequences are kept.
- Reset asserted mid-recovery returns to ACTIVE with counters 0 and cntrst_n=1. The counters are cleared by their own reset.

## Configuration
- FAULT_CONF_AUTOREC_EN defined: bus-off entry goes directly to BOFF_CNT, BOFF_HOLD is unreachable and recover_req is ignored.
- Undefined: bus-off entry goes to BOFF_HOLD and recovery waits for recover_req.

## Structure
- Shared package fault_conf_pkg: state enum type, default RUN_LEN/SEQ_CNT constants.
- One sub-module, rec_run_det: the run counter plus the sequence counter with enable, clear and done outputs. The FSM stays in fault_conf_ctrl.

## Test plan
- Reset with all flags 0 → erroractive=1, cntrst_n=1, seqcount=0; then rec_ge128=1 → errorpassive=1 one cycle later; rec_ge128=0 → erroractive=1.
- In ACTIVE, tec_ge128=1 and tec_ge256=1 in the same cycle → busoff=1 next cycle, PASSIVE never visited.
- Auto mode, bus-off:
  - 1408 recessive samples → seqcount reaches 128, then one cycle of cntrst_n=0, then erroractive=1.
  - 1407 samples → no CLEAR.
- Bus-off, 10 recessive samples, 1 dominant, 11 recessive → seqcount=1.
- Manual mode: 2000 recessive samples in BOFF_HOLD → seqcount=0, busoff=1; recover_req pulse, then 1408 samples → CLEAR then ACTIVE.
- Reset at seqcount=60 → erroractive=1, seqcount=0; re-entering bus-off restarts from 0.

Source files
------------

// File: rtl/fault_conf_pkg.sv
// Shared types and default recovery constants for the CAN fault-confinement controller.
package fault_conf_pkg;

  typedef enum logic [2:0] {
    ST_ACTIVE    = 3'd0,
    ST_PASSIVE   = 3'd1,
    ST_BOFF_HOLD = 3'd2,
    ST_BOFF_CNT  = 3'd3,
    ST_CLEAR     = 3'd4
  } fc_state_e;

  localparam int unsigned RUN_LEN_DEF = 11;
  localparam int unsigned SEQ_CNT_DEF = 128;

endpackage

// File: rtl/rec_run_det.sv
// Bus-off recovery detector: counts runs of RUN_LEN recessive samples and
// the number of completed runs, saturating at SEQ_CNT (SEQ_CNT must be <= 255).
module rec_run_det
  import fault_conf_pkg::*;
#(
  parameter int unsigned RUN_LEN = RUN_LEN_DEF,
  parameter int unsigned SEQ_CNT = SEQ_CNT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       sample_i,
  input  logic       rxbit_i,
  output logic [7:0] seq_cnt_o,
  output logic       done_o
);

  localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);
  localparam int unsigned SEQ_W = $clog2(SEQ_CNT + 1);

  logic [RUN_W-1:0] run_q, run_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             run_done;

  always_comb begin
    run_d    = run_q;
    seq_d    = seq_q;
    run_done = 1'b0;
    if (clr_i) begin
      run_d = '0;
      seq_d = '0;
    end else if (sample_i) begin
      if (!rxbit_i) begin
        run_d = '0;
      end else if (run_q == RUN_W'(RUN_LEN - 1)) begin
        run_d    = '0;
        run_done = 1'b1;
        if (seq_q != SEQ_W'(SEQ_CNT)) seq_d = seq_q + SEQ_W'(1);
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end
  end

  // Flags the sample that completes the final sequence, so the FSM can
  // leave bus-off on the same edge the counter reaches SEQ_CNT.
  assign done_o    = run_done && (seq_q == SEQ_W'(SEQ_CNT - 1));
  assign seq_cnt_o = 8'(seq_q);

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_q <= '0;
      seq_q <= '0;
    end else begin
      run_q <= run_d;
      seq_q <= seq_d;
    end
  end

endmodule

// File: rtl/fault_conf_ctrl.sv
// CAN fault-confinement FSM with bus-off recovery sequencing.
// Define FAULT_CONF_AUTOREC_EN to start recovery automatically on bus-off entry.
//
// state        | meaning
// ACTIVE       | error-active, normal operation
// PASSIVE      | error-passive, TEC or REC >= 128
// BOFF_HOLD    | bus-off, waiting for host recover_req
// BOFF_CNT     | bus-off, counting recessive sequences
// CLEAR        | one-cycle pulse clearing both error counters
module fault_conf_ctrl
  import fault_conf_pkg::*;
#(
  parameter int unsigned RUN_LEN = RUN_LEN_DEF,
  parameter int unsigned SEQ_CNT = SEQ_CNT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tec_ge96,
  input  logic       tec_ge128,
  input  logic       tec_ge256,
  input  logic       rec_ge96,
  input  logic       rec_ge128,
  input  logic       sample,
  input  logic       rxbit,
  input  logic       recover_req,
  output logic       erroractive,
  output logic       errorpassive,
  output logic       busoff,
  output logic       warning,
  output logic       cntrst_n,
  output logic [7:0] seqcount
);

`ifdef FAULT_CONF_AUTOREC_EN
  localparam logic AUTO_REC = 1'b1;
`else
  localparam logic AUTO_REC = 1'b0;
`endif

  localparam fc_state_e BOFF_ENTRY = AUTO_REC ? ST_BOFF_CNT : ST_BOFF_HOLD;

  fc_state_e state_q, state_d;
  logic      erroractive_q, erroractive_d;
  logic      errorpassive_q, errorpassive_d;
  logic      busoff_q, busoff_d;
  logic      cntrst_n_q, cntrst_n_d;
  logic      seq_done;

  rec_run_det #(
    .RUN_LEN (RUN_LEN),
    .SEQ_CNT (SEQ_CNT)
  ) u_rec_run_det (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (state_q != ST_BOFF_CNT),
    .sample_i  (sample),
    .rxbit_i   (rxbit),
    .seq_cnt_o (seqcount),
    .done_o    (seq_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: begin
        if (tec_ge256)                   state_d = BOFF_ENTRY;
        else if (tec_ge128 || rec_ge128) state_d = ST_PASSIVE;
      end
      ST_PASSIVE: begin
        if (tec_ge256)                     state_d = BOFF_ENTRY;
        else if (!tec_ge128 && !rec_ge128) state_d = ST_ACTIVE;
      end
      ST_BOFF_HOLD: if (recover_req && !AUTO_REC) state_d = ST_BOFF_CNT;
      ST_BOFF_CNT:  if (seq_done) state_d = ST_CLEAR;
      ST_CLEAR:     state_d = ST_ACTIVE;
      default:      state_d = ST_ACTIVE;
    endcase

    // Outputs are decoded from the next state so they stay registered.
    erroractive_d  = (state_d == ST_ACTIVE) || (state_d == ST_CLEAR);
    errorpassive_d = (state_d == ST_PASSIVE);
    busoff_d       = (state_d == ST_BOFF_HOLD) || (state_d == ST_BOFF_CNT);
    cntrst_n_d     = (state_d != ST_CLEAR);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_ACTIVE;
      erroractive_q  <= 1'b1;
      errorpassive_q <= 1'b0;
      busoff_q       <= 1'b0;
      cntrst_n_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      erroractive_q  <= erroractive_d;
      errorpassive_q <= errorpassive_d;
      busoff_q       <= busoff_d;
      cntrst_n_q     <= cntrst_n_d;
    end
  end

  assign erroractive  = erroractive_q;
  assign errorpassive = errorpassive_q;
  assign busoff       = busoff_q;
  assign cntrst_n     = cntrst_n_q;
  assign warning      = (tec_ge96 || rec_ge96) && !busoff_q;

endmodule

// File: tb/tb_fault_conf_ctrl.sv
// Scoreboard bench for fault_conf_ctrl: directed recovery scenarios plus random traffic.
module tb_fault_conf_ctrl;

  localparam int RUN_LEN = 11;
  localparam int SEQ_CNT = 128;
`ifdef FAULT_CONF_AUTOREC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int M_ACT = 0, M_PAS = 1, M_HOLD = 2, M_CNT = 3, M_CLR = 4;

  logic       clock = 1'b0;
  logic       reset, tec_ge96, tec_ge128, tec_ge256, rec_ge96, rec_ge128;
  logic       sample, rxbit, recover_req;
  logic       erroractive, errorpassive, busoff, warning, cntrst_n;
  logic [7:0] seqcount;

  always #5 clock = ~clock;

  fault_conf_ctrl #(.RUN_LEN(RUN_LEN), .SEQ_CNT(SEQ_CNT)) dut (
    .clock        (clock),
    .reset        (reset),
    .tec_ge96     (tec_ge96),
    .tec_ge128    (tec_ge128),
    .tec_ge256    (tec_ge256),
    .rec_ge96     (rec_ge96),
    .rec_ge128    (rec_ge128),
    .sample       (sample),
    .rxbit        (rxbit),
    .recover_req  (recover_req),
    .erroractive  (erroractive),
    .errorpassive (errorpassive),
    .busoff       (busoff),
    .warning      (warning),
    .cntrst_n     (cntrst_n),
    .seqcount     (seqcount)
  );

  typedef struct packed {
    logic       ea, ep, bo, wn, crn;
    logic [7:0] sc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: node state plus recessive-run and completed-sequence counts.
  bit model_known = 1'b0;
  int ms = M_ACT;
  int m_run = 0;
  int m_seq = 0;

  // Current flag levels (consistent threshold ladders).
  bit ft96 = 0, ft128 = 0, ft256 = 0, fr96 = 0, fr128 = 0;

  task automatic set_tec(input int lvl);
    ft96  = (lvl >= 1);
    ft128 = (lvl >= 2);
    ft256 = (lvl >= 3);
  endtask

  task automatic set_rec(input int lvl);
    fr96  = (lvl >= 1);
    fr128 = (lvl >= 2);
  endtask

  function automatic void model_step(input bit rst, input bit t128, input bit t256,
                                     input bit r128, input bit smp, input bit rx, input bit req);
    int boff_target;
    boff_target = AUTO ? M_CNT : M_HOLD;
    if (!rst) begin
      ms = M_ACT; m_run = 0; m_seq = 0;
      return;
    end
    if (ms == M_CNT) begin
      if (smp) begin
        if (!rx) m_run = 0;
        else begin
          m_run++;
          if (m_run == RUN_LEN) begin
            m_run = 0;
            m_seq++;
            if (m_seq == SEQ_CNT) ms = M_CLR;
          end
        end
      end
    end else begin
      m_run = 0; m_seq = 0;
      case (ms)
        M_ACT:  if (t256) ms = boff_target; else if (t128 || r128) ms = M_PAS;
        M_PAS:  if (t256) ms = boff_target; else if (!t128 && !r128) ms = M_ACT;
        M_HOLD: if (req && !AUTO) ms = M_CNT;
        default: ms = M_ACT;
      endcase
    end
  endfunction

  // One clock cycle: drive inputs, queue what the outputs must show this cycle, advance model.
  task automatic cyc(input bit rst, input bit smp, input bit rx, input bit req);
    exp_t e;
    @(posedge clock); #1;
    reset = rst; tec_ge96 = ft96; tec_ge128 = ft128; tec_ge256 = ft256;
    rec_ge96 = fr96; rec_ge128 = fr128; sample = smp; rxbit = rx; recover_req = req;
    if (model_known) begin
      e.ea  = (ms == M_ACT) || (ms == M_CLR);
      e.ep  = (ms == M_PAS);
      e.bo  = (ms == M_HOLD) || (ms == M_CNT);
      e.wn  = (ft96 || fr96) && !e.bo;
      e.crn = (ms != M_CLR);
      e.sc  = 8'(m_seq);
      exp_q.push_back(e);
    end
    model_step(rst, ft128, ft256, fr128, smp, rx, req);
    if (!rst) model_known = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic recessive(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic enter_busoff_and_release();
    set_tec(3);
    idle(1);
    set_tec(0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if ({erroractive, errorpassive, busoff, warning, cntrst_n, seqcount} !== mon_e) begin
        n_err++;
        $display("FAIL outputs t=%0t actual ea=%b ep=%b bo=%b wn=%b crn=%b sc=%0d required ea=%b ep=%b bo=%b wn=%b crn=%b sc=%0d",
                 $time, erroractive, errorpassive, busoff, warning, cntrst_n, seqcount,
                 mon_e.ea, mon_e.ep, mon_e.bo, mon_e.wn, mon_e.crn, mon_e.sc);
      end
    end
  end

  initial begin
    reset = 1'b0; tec_ge96 = 0; tec_ge128 = 0; tec_ge256 = 0; rec_ge96 = 0; rec_ge128 = 0;
    sample = 0; rxbit = 0; recover_req = 0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Passive and back via REC.
    set_rec(2); idle(3);
    set_rec(0); idle(3);
    set_rec(1); idle(2);
    set_rec(0);

    // TEC >= 128 and >= 256 together: straight to bus-off.
    set_tec(3); idle(3);
    set_tec(0);

    // Recessive traffic while held, then host-requested recovery.
    recessive(2000);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    recessive(SEQ_CNT * RUN_LEN);
    idle(4);

    // One sample short of recovery, then the completing sample.
    enter_busoff_and_release();
    recessive(SEQ_CNT * RUN_LEN - 1);
    idle(5);
    recessive(1);
    idle(3);

    // A dominant bit loses only the current run.
    enter_busoff_and_release();
    recessive(10);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    recessive(RUN_LEN);
    idle(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Reset mid-recovery, then recovery restarts from zero.
    enter_busoff_and_release();
    recessive(60 * RUN_LEN);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    enter_busoff_and_release();
    recessive(2 * RUN_LEN + 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) set_tec($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) set_rec($urandom_range(0, 2));
      cyc($urandom_range(0, 2999) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 99) != 0, $urandom_range(0, 149) == 0);
    end

    @(negedge clock); #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
